// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the iterative signed divider: state encoding and default width.
// The control FSM uses DIV_WIDTH to size its DIV wait-state timing.
package seq_signed_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_signed_divider_if.sv
// Request/result bundle between the control FSM (master) and the divider (slave).
interface seq_signed_divider_if
    import seq_signed_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_signed_divider_clz.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
// Only compiled when DIV_LEADING_ZERO_SKIP_EN is defined.
`ifdef DIV_LEADING_ZERO_SKIP_EN
module seq_signed_divider_clz #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [CNT_W-1:0] o_lz_c
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        o_lz_c = CNT_W'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i_val[i]) begin
                o_lz_c = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`endif

// File: rtl/seq_signed_divider.sv
// Iterative restoring signed divider (one quotient bit per cycle) for the DIV instruction.
// Optional DIV_LEADING_ZERO_SKIP_EN skips the leading zeros of |a| to shorten latency.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    seq_signed_divider_if.slave   div_if
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned XW    = WIDTH + 1;

    div_state_e       r_state;
    div_state_e       w_state_nx;

    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem_o;

    logic             r_sa;
    logic             r_sb;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [XW-1:0]    r_dvs;

    logic             w_busy_nx;
    logic             w_done_nx;
    logic [WIDTH-1:0] w_abs_a;
    logic [XW-1:0]    w_abs_b;
    logic             w_b_zero;
    logic [XW-1:0]    w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_dvd_init;
    logic [CNT_W-1:0] w_cnt_init;
    logic             w_skip;

    // Magnitudes in WIDTH+1 bits so that |INT_MIN| is exact.
    assign w_abs_a  = div_if.a[WIDTH-1] ? WIDTH'(XW'(0) - {div_if.a[WIDTH-1], div_if.a})
                                        : div_if.a;
    assign w_abs_b  = div_if.b[WIDTH-1] ? XW'(0) - {div_if.b[WIDTH-1], div_if.b}
                                        : {1'b0, div_if.b};
    assign w_b_zero = (div_if.b == '0);

`ifdef DIV_LEADING_ZERO_SKIP_EN
    logic [CNT_W-1:0] w_lz;

    seq_signed_divider_clz #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_clz (
        .i_val  (w_abs_a),
        .o_lz_c (w_lz)
    );

    // Pre-shifting out the zeros leaves the quotient bit pattern unchanged.
    assign w_dvd_init = w_abs_a << w_lz;
    assign w_cnt_init = CNT_W'(WIDTH) - w_lz;
    assign w_skip     = (w_lz == CNT_W'(WIDTH));
`else
    assign w_dvd_init = w_abs_a;
    assign w_cnt_init = CNT_W'(WIDTH);
    assign w_skip     = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= r_dvs);

    assign w_q_fix  = (r_sa ^ r_sb) ? WIDTH'(0) - r_dvd : r_dvd;
    assign w_r_fix  = r_sa ? WIDTH'(0) - r_rem : r_rem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (div_if.start) begin
                    if (w_b_zero) begin
                        w_done_nx = 1'b1;
                    end else begin
                        w_busy_nx  = 1'b1;
                        w_state_nx = w_skip ? S_SIGN : S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_SIGN;
                end
            end
            S_SIGN: begin
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; results hold until the next accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_rem_o <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
        end else begin
            r_busy <= w_busy_nx;
            r_done <= w_done_nx;
            case (r_state)
                S_IDLE: begin
                    if (div_if.start) begin
                        r_sa  <= div_if.a[WIDTH-1];
                        r_sb  <= div_if.b[WIDTH-1];
                        r_dbz <= 1'b0;
                        if (w_b_zero) begin
                            r_quot  <= '0;
                            r_rem_o <= div_if.a;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_dvd <= w_dvd_init;
                            r_dvs <= w_abs_b;
                            r_rem <= '0;
                            r_cnt <= w_cnt_init;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? WIDTH'(w_rem_sh - r_dvs) : w_rem_sh[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_SIGN: begin
                    r_quot  <= w_q_fix;
                    r_rem_o <= w_r_fix;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign div_if.busy        = r_busy;
    assign div_if.done        = r_done;
    assign div_if.quotient    = r_quot;
    assign div_if.remainder   = r_rem_o;
    assign div_if.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider; latency expectations follow
// DIV_LEADING_ZERO_SKIP_EN when it is defined.
module tb_seq_signed_divider;
    import seq_signed_divider_pkg::*;

    localparam int unsigned W = DIV_WIDTH;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] prev_q = '0;

    always #5 clk = ~clk;

    seq_signed_divider_if #(.WIDTH(W)) div_if ();

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_if  (div_if)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle (start cycle = 0) in which done is expected.
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_LEADING_ZERO_SKIP_EN
        logic [W-1:0] m;
        int lz;
`endif
        if (b == '0) return 1;
`ifdef DIV_LEADING_ZERO_SKIP_EN
        m  = a[W-1] ? W'(0) - a : a;
        lz = W;
        for (int i = 0; i < int'(W); i++) begin
            if (m[i]) lz = W - 1 - i;
        end
        return (W - lz) + 2;
`else
        return W + 2;
`endif
    endfunction

    // Waits for done starting in cycle cyc; lat stays -1 if the budget runs out.
    task automatic wait_done(input int start_cyc, output int lat, output bit busy_seen,
                             output logic [W-1:0] q1, output logic d1);
        int cyc;
        cyc       = start_cyc;
        lat       = -1;
        busy_seen = 1'b0;
        q1        = '0;
        d1        = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            if (cyc == 1) begin
                q1 = div_if.quotient;
                d1 = div_if.div_by_zero;
            end
            if (div_if.busy) busy_seen = 1'b1;
            if (div_if.done) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge; start is raised in that cycle (cycle 0).
    task automatic run_div(input string tag, input vec_t v);
        int lat;
        bit busy_seen;
        logic [W-1:0] q1;
        logic d1;
        div_if.a     = v.a;
        div_if.b     = v.b;
        div_if.start = 1'b1;
        @(posedge clk);
        #1 div_if.start = 1'b0;
        wait_done(1, lat, busy_seen, q1, d1);
        check_eq({tag, ".lat"}, W'(lat), W'(exp_lat(v.a, v.b)));
        check_eq({tag, ".q"}, div_if.quotient, v.q);
        check_eq({tag, ".r"}, div_if.remainder, v.r);
        check_eq({tag, ".dbz"}, W'(div_if.div_by_zero), W'(v.dbz));
        check_eq({tag, ".busy"}, W'(busy_seen), W'(v.b != '0));
        if (v.b != '0) begin
            check_eq({tag, ".hold_q"}, q1, prev_q);
            check_eq({tag, ".dbz_clr"}, W'(d1), W'(0));
        end
        prev_q = v.q;
    endtask

    vec_t vecs[16] = '{
        '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0},
        '{-32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0},
        '{32'd100,        -32'sd7,        -32'sd14,       32'd2,          1'b0},
        '{-32'sd100,      -32'sd7,        32'd14,         -32'sd2,        1'b0},
        '{32'd5,          32'd0,          32'd0,          32'd5,          1'b1},
        '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0},
        '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0},
        '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0},
        '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0},
        '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0},
        '{32'hFFFF_FFFF,  32'd0,          32'd0,          32'hFFFF_FFFF,  1'b1},
        '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0},
        '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0},
        '{-32'sd7,        32'd2,          -32'sd3,        -32'sd1,        1'b0},
        '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0},
        '{32'h1234_5678,  32'h10,         32'h0123_4567,  32'd8,          1'b0}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int done_cnt;
        bit busy_seen;
        logic [W-1:0] q1;
        logic d1;
        vec_t v;
        longint sa;
        longint sb;

        div_if.start = 1'b0;
        div_if.a     = '0;
        div_if.b     = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.busy", W'(div_if.busy), W'(0));
        check_eq("rst.done", W'(div_if.done), W'(0));
        check_eq("rst.dbz", W'(div_if.div_by_zero), W'(0));
        check_eq("rst.q", div_if.quotient, W'(0));
        check_eq("rst.r", div_if.remainder, W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Back-to-back vectors: each start is raised in the previous done cycle.
        foreach (vecs[i]) begin
            run_div($sformatf("vec%0d", i), vecs[i]);
        end

        @(negedge clk);
        check_eq("done.pulse", W'(div_if.done), W'(0));

        // A start pulse while busy must not restart the operation.
        div_if.a     = 32'd100;
        div_if.b     = 32'd7;
        div_if.start = 1'b1;
        @(posedge clk);
        #1 div_if.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        div_if.a     = 32'd1;
        div_if.b     = 32'd1;
        div_if.start = 1'b1;
        @(posedge clk);
        #1 div_if.start = 1'b0;
        wait_done(6, lat, busy_seen, q1, d1);
        check_eq("ign.lat", W'(lat), W'(exp_lat(32'd100, 32'd7)));
        check_eq("ign.q", div_if.quotient, 32'd14);
        check_eq("ign.r", div_if.remainder, 32'd2);

        // Reset in the middle of an operation.
        div_if.a     = 32'd100;
        div_if.b     = 32'd7;
        div_if.start = 1'b1;
        @(posedge clk);
        #1 div_if.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("abort.busy", W'(div_if.busy), W'(0));
        check_eq("abort.done", W'(div_if.done), W'(0));
        check_eq("abort.q", div_if.quotient, W'(0));
        check_eq("abort.r", div_if.remainder, W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_if.done) done_cnt++;
        end
        check_eq("abort.no_done", W'(done_cnt), W'(0));
        prev_q = '0;
        v = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        run_div("after_rst", v);

        // Random operands against a 64-bit reference.
        for (int n = 0; n < 100; n++) begin
            v.a = W'($urandom) >> $urandom_range(0, 31);
            v.b = W'($urandom) >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v.a = W'(0) - v.a;
            if ($urandom_range(0, 1) == 1) v.b = W'(0) - v.b;
            if (v.b == '0) v.b = 32'd3;
            sa    = longint'($signed(v.a));
            sb    = longint'($signed(v.b));
            v.q   = W'(sa / sb);
            v.r   = W'(sa % sb);
            v.dbz = 1'b0;
            run_div($sformatf("rnd%0d", n), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
